// File: rtl/stream_minmax_tracker_if.sv
// Sample-in / result-out handshake bundle for stream_minmax_tracker.
//   in_valid/in_ready/in_data      : sample stream into the tracker
//   out_valid/out_ready            : held result handshake
//   out_min/out_max/out_ties       : window result (ties = count of samples equal to max)
// master: the producer/consumer side; slave: the tracker.
interface stream_minmax_tracker_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned WINDOW = 16
);
    localparam int unsigned TIES_W = $clog2(WINDOW + 1);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_min;
    logic [WIDTH-1:0]  out_max;
    logic [TIES_W-1:0] out_ties;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_ties
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_min, out_max, out_ties
    );
endinterface

// File: rtl/stream_minmax_tracker.sv
// Windowed running min/max tracker.
// Accepts WINDOW unsigned samples, then holds min, max and the number of
// samples equal to max on the output handshake until taken.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   clear : synchronous abort of the current window / pending result
//   bus   : stream_minmax_tracker_if slave (sample in, result out)

// Unsigned magnitude comparator with cascade inputs; cascade values pass
// through only when a == b.
module stream_minmax_cmp #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             l_i,
    input  logic             g_i,
    input  logic             q_i,
    output logic             lt_c,
    output logic             gt_c,
    output logic             eq_c
);
    always_comb begin
        lt_c = 1'b0;
        gt_c = 1'b0;
        eq_c = 1'b0;
        if (a_i > b_i) begin
            gt_c = 1'b1;
        end else if (a_i < b_i) begin
            lt_c = 1'b1;
        end else begin
            lt_c = l_i;
            gt_c = g_i;
            eq_c = q_i;
        end
    end
endmodule

module stream_minmax_tracker #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned WINDOW = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    stream_minmax_tracker_if.slave      bus
);
    localparam int unsigned CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned TIES_W = $clog2(WINDOW + 1);

    typedef enum logic {
        S_FILL   = 1'b0,
        S_REPORT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  min_q, min_d;
    logic [WIDTH-1:0]  max_q, max_d;
    logic [TIES_W-1:0] ties_q, ties_d;
    logic [WIDTH-1:0]  out_min_q, out_min_d;
    logic [WIDTH-1:0]  out_max_q, out_max_d;
    logic [TIES_W-1:0] out_ties_q, out_ties_d;

    logic              max_lt, max_gt, max_eq;
    logic              min_lt, min_gt, min_eq;

    // Window state after folding in the current sample
    logic [WIDTH-1:0]  upd_min;
    logic [WIDTH-1:0]  upd_max;
    logic [TIES_W-1:0] upd_ties;

    // Sample vs running max
    stream_minmax_cmp #(.WIDTH(WIDTH)) u_cmp_max (
        .a_i  (bus.in_data),
        .b_i  (max_q),
        .l_i  (1'b0),
        .g_i  (1'b0),
        .q_i  (1'b1),
        .lt_c (max_lt),
        .gt_c (max_gt),
        .eq_c (max_eq)
    );

    // Sample vs running min
    stream_minmax_cmp #(.WIDTH(WIDTH)) u_cmp_min (
        .a_i  (bus.in_data),
        .b_i  (min_q),
        .l_i  (1'b0),
        .g_i  (1'b0),
        .q_i  (1'b1),
        .lt_c (min_lt),
        .gt_c (min_gt),
        .eq_c (min_eq)
    );

    // Fold the incoming sample into the running min/max/ties
    always_comb begin
        upd_min  = min_q;
        upd_max  = max_q;
        upd_ties = ties_q;
        if (cnt_q == '0) begin
            // First sample seeds the window; running regs may hold stale data
            upd_min  = bus.in_data;
            upd_max  = bus.in_data;
            upd_ties = TIES_W'(1);
        end else begin
            case ({max_gt, max_eq, max_lt})
                3'b100: begin
                    upd_max  = bus.in_data;
                    upd_ties = TIES_W'(1);
                end
                3'b010:  upd_ties = ties_q + TIES_W'(1);
                default: ;
            endcase
            case ({min_gt, min_eq, min_lt})
                3'b001:  upd_min = bus.in_data;
                default: ;
            endcase
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        min_d      = min_q;
        max_d      = max_q;
        ties_d     = ties_q;
        out_min_d  = out_min_q;
        out_max_d  = out_max_q;
        out_ties_d = out_ties_q;

        if (clear) begin
            // cnt=0 makes the next sample reseed, discarding the partial window
            state_d = S_FILL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (bus.in_valid) begin
                        if (cnt_q == CNT_W'(WINDOW - 1)) begin
                            out_min_d  = upd_min;
                            out_max_d  = upd_max;
                            out_ties_d = upd_ties;
                            state_d    = S_REPORT;
                            cnt_d      = '0;
                        end else begin
                            min_d  = upd_min;
                            max_d  = upd_max;
                            ties_d = upd_ties;
                            cnt_d  = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_REPORT: begin
                    if (bus.out_ready) begin
                        state_d = S_FILL;
                    end
                end
                default: state_d = S_FILL;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            cnt_q      <= '0;
            min_q      <= '0;
            max_q      <= '0;
            ties_q     <= '0;
            out_min_q  <= '0;
            out_max_q  <= '0;
            out_ties_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            min_q      <= min_d;
            max_q      <= max_d;
            ties_q     <= ties_d;
            out_min_q  <= out_min_d;
            out_max_q  <= out_max_d;
            out_ties_q <= out_ties_d;
        end
    end

    // Handshakes decode straight from the state flop
    assign bus.in_ready  = (state_q == S_FILL);
    assign bus.out_valid = (state_q == S_REPORT);
    assign bus.out_min   = out_min_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_ties  = out_ties_q;
endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Self-checking bench for stream_minmax_tracker (WIDTH=8, WINDOW=4).
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a window-level reference model.
module tb_stream_minmax_tracker;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned WINDOW = 4;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    stream_minmax_tracker_if #(.WIDTH(WIDTH), .WINDOW(WINDOW)) bus ();

    stream_minmax_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: collected samples and last published result
    bit               m_report;
    logic [WIDTH-1:0] m_win[$];
    int unsigned      m_min;
    int unsigned      m_max;
    int unsigned      m_ties;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one clock edge to the model using the inputs currently driven
    task automatic model_edge();
        int unsigned mn, mx, tc;
        if (rst) begin
            m_report = 1'b0;
            m_win.delete();
            m_min  = 0;
            m_max  = 0;
            m_ties = 0;
        end else if (clear) begin
            m_report = 1'b0;
            m_win.delete();
        end else if (!m_report) begin
            if (bus.in_valid) begin
                m_win.push_back(bus.in_data);
                if (m_win.size() == WINDOW) begin
                    mn = 255;
                    mx = 0;
                    foreach (m_win[i]) begin
                        if (m_win[i] < mn) mn = m_win[i];
                        if (m_win[i] > mx) mx = m_win[i];
                    end
                    tc = 0;
                    foreach (m_win[i]) if (m_win[i] == mx) tc++;
                    m_min    = mn;
                    m_max    = mx;
                    m_ties   = tc;
                    m_report = 1'b1;
                    m_win.delete();
                end
            end
        end else if (bus.out_ready) begin
            m_report = 1'b0;
        end
    endtask

    // One clock: update model at the edge, compare DUT 1ns later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("in_ready",  bus.in_ready,  !m_report);
        check_val("out_valid", bus.out_valid, m_report);
        check_val("out_min",   bus.out_min,   m_min);
        check_val("out_max",   bus.out_max,   m_max);
        check_val("out_ties",  bus.out_ties,  m_ties);
    endtask

    task automatic send(input int unsigned v);
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'(v);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int unsigned mn, input int unsigned mx,
                                 input int unsigned tc);
        check_val({tag, "_valid"}, bus.out_valid, 1);
        check_val({tag, "_min"},   bus.out_min,   mn);
        check_val({tag, "_max"},   bus.out_max,   mx);
        check_val({tag, "_ties"},  bus.out_ties,  tc);
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    function automatic int unsigned pick_data();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return 255;
            2:       return $urandom_range(0, 255);
            default: return $urandom_range(100, 103);
        endcase
    endfunction

    initial begin
        rst          = 1'b1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_val("rst_in_ready",  bus.in_ready,  1);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_min",   bus.out_min,   0);
        check_val("rst_out_max",   bus.out_max,   0);
        check_val("rst_out_ties",  bus.out_ties,  0);

        // All equal
        send(87); send(87); send(87);
        check_val("eq_not_yet", bus.out_valid, 0);
        send(87);
        expect_result("all_eq", 87, 87, 4);
        check_val("eq_in_ready", bus.in_ready, 0);
        take_result();

        // Mixed with ties, then a fresh window
        send(10); send(200); send(5); send(200);
        expect_result("mixed1", 5, 200, 2);
        take_result();
        send(201); send(3); send(3); send(3);
        expect_result("mixed2", 3, 201, 1);
        take_result();

        // Extremes
        send(255); send(0); send(255); send(128);
        expect_result("extreme", 0, 255, 2);

        // Backpressure with a sample waiting
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd77;
        repeat (5) begin
            step();
            check_val("bp_in_ready", bus.in_ready, 0);
        end
        expect_result("bp_hold", 0, 255, 2);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_val("bp_release", bus.in_ready, 1);
        send(77); send(78); send(79); send(77);
        expect_result("bp_next", 77, 79, 1);
        take_result();

        // Clear mid-window, with a sample offered on the clear cycle
        send(1); send(2);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd99;
        step();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        send(50); send(40); send(60);
        check_val("clr_not_yet", bus.out_valid, 0);
        send(60);
        expect_result("clear", 40, 60, 2);

        // Clear during REPORT drops the result
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_val("clr_rep_valid", bus.out_valid, 0);
        check_val("clr_rep_ready", bus.in_ready,  1);

        // Reset mid-window
        send(1); send(2); send(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rstw_in_ready", bus.in_ready, 1);
        check_val("rstw_min",      bus.out_min,  0);
        check_val("rstw_max",      bus.out_max,  0);
        check_val("rstw_ties",     bus.out_ties, 0);
        send(9); send(9); send(8); send(7);
        expect_result("rst_win", 7, 9, 2);
        take_result();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = WIDTH'(pick_data());
            bus.out_ready = ($urandom_range(0, 2) == 0);
            clear         = ($urandom_range(0, 59) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            step();
        end
        rst   = 1'b0;
        clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
